// File: rtl/pcie_pack_fifo_pkg.sv
// Shared defaults and helpers for the lane-packing FIFO.
// The lane counter is the only width derived from RATIO, so it is defined here once.
package pcie_pack_fifo_pkg;

  localparam int DEF_IN_W    = 16;
  localparam int DEF_RATIO   = 8;
  localparam int DEF_DEPTH_W = 10;
  localparam int DEF_AF_NUM  = 1016;
  localparam int DEF_AE_NUM  = 4;

  // The pack count runs 0..ratio-1. Because ratio is a power of two, clog2 bits are enough.
  function automatic int lane_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  localparam int DEF_LANE_CNT_W = lane_cnt_w(DEF_RATIO);

endpackage

// File: rtl/pcie_pack_fifo_ram.sv
// Simple dual-port word store with a registered read port.
// Only the read register is reset. The array stays uninitialised.
module pcie_pack_fifo_ram
  import pcie_pack_fifo_pkg::*;
#(
  parameter int AW = DEF_DEPTH_W,
  parameter int DW = DEF_IN_W * DEF_RATIO + DEF_RATIO
) (
  input  logic          clk,
  input  logic          tb_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register holds its value between reads, so the word it presents stays stable.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pcie_pack_fifo.sv
// Packs RATIO narrow lanes into one wide word and buffers the words in a FIFO.
// A flush commits a partial word together with a valid-lane mask.
module pcie_pack_fifo
  import pcie_pack_fifo_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int RATIO   = DEF_RATIO,
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int AF_NUM  = DEF_AF_NUM,
  parameter int AE_NUM  = DEF_AE_NUM
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  wr_en,
  input  logic [IN_W-1:0]       wr_data,
  input  logic                  flush,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [IN_W*RATIO-1:0] rd_data,
  output logic [RATIO-1:0]      rd_keep,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [DEPTH_W:0]      rd_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf_err,
  output logic                  unf_err,
  input  logic                  err_clr
);

  localparam int W  = IN_W * RATIO;
  localparam int CW = lane_cnt_w(RATIO);
  localparam logic [CW-1:0]    LAST_LANE = CW'(RATIO - 1);
  localparam logic [DEPTH_W:0] FULL_LVL  = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] AF_LVL    = (DEPTH_W+1)'(AF_NUM);
  localparam logic [DEPTH_W:0] AE_LVL    = (DEPTH_W+1)'(AE_NUM);

  logic [CW-1:0]      pack_cnt, cnt_next;
  logic [W-1:0]       pack_word, word_next, merged;
  logic [CW:0]        lanes_n;
  logic [RATIO-1:0]   commit_keep;
  logic               lane_acc, rd_acc, commit, ovf_set, unf_set;
  logic [DEPTH_W:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level_next;
  logic [W+RATIO-1:0] ram_q;

  assign lane_acc = wr_en & ~wr_full;
  assign rd_acc   = rd_en & ~rd_empty;
  assign ovf_set  = (wr_en | flush) & wr_full;
  assign unf_set  = rd_en & rd_empty;

  // Merge the incoming lane first, so that a write and a flush in the same cycle commit one word.
  always_comb begin
    merged      = pack_word;
    lanes_n     = {1'b0, pack_cnt};
    commit      = 1'b0;
    commit_keep = '0;
    cnt_next    = pack_cnt;
    word_next   = pack_word;
    if (lane_acc) begin
      merged[int'(pack_cnt)*IN_W +: IN_W] = wr_data;
      lanes_n = {1'b0, pack_cnt} + (CW+1)'(1);
    end
    if (lane_acc && (pack_cnt == LAST_LANE)) commit = 1'b1;
    if (flush && !wr_full && (lanes_n != '0)) commit = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      commit_keep[k] = (k < int'(lanes_n));
    end
    if (commit) begin
      cnt_next  = '0;
      word_next = '0;
    end else begin
      cnt_next  = lanes_n[CW-1:0];
      word_next = merged;
    end
  end

  assign wr_ptr_next = wr_ptr + (DEPTH_W+1)'(commit);
  assign rd_ptr_next = rd_ptr + (DEPTH_W+1)'(rd_acc);
  assign level_next  = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      pack_cnt     <= '0;
      pack_word    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf_err      <= 1'b0;
      unf_err      <= 1'b0;
    end else begin
      pack_cnt     <= cnt_next;
      pack_word    <= word_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      rd_level     <= level_next;
      rd_valid     <= rd_acc;
      wr_full      <= (level_next == FULL_LVL);
      rd_empty     <= (level_next == '0);
      almost_full  <= (level_next >= AF_LVL);
      almost_empty <= (level_next <= AE_LVL);
      ovf_err      <= ovf_set | (ovf_err & ~err_clr);
      unf_err      <= unf_set | (unf_err & ~err_clr);
    end
  end

  pcie_pack_fifo_ram #(
    .AW(DEPTH_W),
    .DW(W + RATIO)
  ) u_ram (
    .clk    (clk),
    .tb_rst (tb_rst),
    .wr_en  (commit),
    .wr_addr(wr_ptr[DEPTH_W-1:0]),
    .wr_data({commit_keep, merged}),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr[DEPTH_W-1:0]),
    .rd_data(ram_q)
  );

  assign rd_data = ram_q[W-1:0];
  assign rd_keep = ram_q[W +: RATIO];

endmodule

// File: tb/tb_pcie_pack_fifo.sv
// Randomised and directed bench for pcie_pack_fifo, checked against a queue-based model.
// The model tracks committed words, pending lanes and the sticky flags at the word level.
module tb_pcie_pack_fifo;

  localparam int IN_W = 16, RATIO = 8, DEPTH_W = 4, AF_NUM = 14, AE_NUM = 2;
  localparam int W = IN_W * RATIO;
  localparam int DEPTH = 2 ** DEPTH_W;

  typedef struct {
    logic [W-1:0]     data;
    logic [RATIO-1:0] keep;
  } word_t;

  logic                clk = 1'b0;
  logic                tb_rst, wr_en, flush, rd_en, err_clr;
  logic [IN_W-1:0]     wr_data;
  logic                wr_full, rd_valid, rd_empty, almost_full, almost_empty, ovf_err, unf_err;
  logic [W-1:0]        rd_data;
  logic [RATIO-1:0]    rd_keep;
  logic [DEPTH_W:0]    rd_level;

  int n_checks = 0;
  int n_fail   = 0;

  word_t           mq[$];
  logic [IN_W-1:0] lanes[$];
  logic            m_ovf, m_unf, m_valid;
  logic [W-1:0]    m_data;
  logic [RATIO-1:0] m_keep;

  pcie_pack_fifo #(
    .IN_W(IN_W), .RATIO(RATIO), .DEPTH_W(DEPTH_W), .AF_NUM(AF_NUM), .AE_NUM(AE_NUM)
  ) dut (
    .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .wr_full(wr_full), .rd_en(rd_en), .rd_data(rd_data), .rd_keep(rd_keep),
    .rd_valid(rd_valid), .rd_empty(rd_empty), .rd_level(rd_level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    lanes.delete();
    m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0; m_keep = '0;
  endtask

  // A read sees only words committed before this edge. The pop happens before the push.
  task automatic model_step(input logic we, input logic [IN_W-1:0] wd, input logic fl,
                            input logic re, input logic ec);
    bit full, empty;
    word_t w, r;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_valid = re && !empty;
    if (re && !empty) begin
      r = mq.pop_front();
      m_data = r.data;
      m_keep = r.keep;
    end
    if (we && !full) lanes.push_back(wd);
    if (!full && (lanes.size() == RATIO || (fl && lanes.size() > 0))) begin
      w.data = '0;
      w.keep = '0;
      foreach (lanes[k]) begin
        w.data[k*IN_W +: IN_W] = lanes[k];
        w.keep[k] = 1'b1;
      end
      mq.push_back(w);
      lanes.delete();
    end
    m_ovf = ((we || fl) && full) || (m_ovf && !ec);
    m_unf = (re && empty) || (m_unf && !ec);
  endtask

  task automatic drive(input logic we, input logic [IN_W-1:0] wd, input logic fl,
                       input logic re, input logic ec);
    wr_en = we; wr_data = wd; flush = fl; rd_en = re; err_clr = ec;
    @(posedge clk);
    model_step(we, wd, fl, re, ec);
    @(negedge clk);
    wr_en = 0; flush = 0; rd_en = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (rd_level !== '0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d want 0", rd_level); end
    n_checks++; if ({rd_empty, almost_empty} !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_empty_flags: got %b want 11", {rd_empty, almost_empty}); end
    n_checks++; if ({wr_full, almost_full, rd_valid, ovf_err, unf_err} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 00000", {wr_full, almost_full, rd_valid, ovf_err, unf_err}); end
    n_checks++; if ({rd_data, rd_keep} !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", rd_data, rd_keep); end
    tb_rst = 0;
    @(negedge clk);
    n_checks++; if (rd_empty !== 1'b1 || rd_level !== '0) begin n_fail++; $display("[TB] FAIL post_reset_idle: got empty=%b level=%0d want 1/0", rd_empty, rd_level); end
  endtask

  task automatic test_full_word();
    for (int i = 0; i < RATIO; i++) drive(1, 16'hFFFF - 16'(i), 0, 0, 0);
    n_checks++; if (rd_level !== 5'd1) begin n_fail++; $display("[TB] FAIL full_word_level: got %0d want 1", rd_level); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_word_valid: got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF || rd_data !== m_data) begin n_fail++; $display("[TB] FAIL full_word_data: got %h want %h", rd_data, m_data); end
    n_checks++; if (rd_keep !== 8'hFF) begin n_fail++; $display("[TB] FAIL full_word_keep: got %h want ff", rd_keep); end
    n_checks++; if (rd_level !== 5'd0 || rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL full_word_drain: got level=%0d empty=%b want 0/1", rd_level, rd_empty); end
    drive(0, 0, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== m_data) begin n_fail++; $display("[TB] FAIL hold_data: got v=%b %h want 0 %h", rd_valid, rd_data, m_data); end
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 0, 0);
    n_checks++; if (rd_level !== 5'd0) begin n_fail++; $display("[TB] FAIL empty_flush_noop: got level %0d want 0", rd_level); end
    drive(1, 16'h0001, 0, 0, 0);
    drive(1, 16'h0002, 0, 0, 0);
    drive(1, 16'h0003, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    n_checks++; if (rd_level !== 5'd1) begin n_fail++; $display("[TB] FAIL flush_level: got %0d want 1", rd_level); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if (rd_data !== 128'h0003_0002_0001 || rd_keep !== 8'h07) begin n_fail++; $display("[TB] FAIL flush_partial: got %h/%h want 30002_0001/07", rd_data, rd_keep); end
    drive(1, 16'hABCD, 1, 0, 0);
    for (int i = 0; i < RATIO - 1; i++) drive(1, 16'(i + 16'h10), 0, 0, 0);
    drive(1, 16'h5A5A, 1, 0, 0);
    n_checks++; if (rd_level !== 5'd2 || rd_level !== 5'(mq.size())) begin n_fail++; $display("[TB] FAIL flush_same_cycle_level: got %0d want 2", rd_level); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if (rd_keep !== 8'h01 || rd_data !== 128'hABCD) begin n_fail++; $display("[TB] FAIL single_lane_word: got %h/%h want abcd/01", rd_data, rd_keep); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if (rd_keep !== 8'hFF || rd_data !== m_data) begin n_fail++; $display("[TB] FAIL last_lane_flush: got %h/%h want %h/ff", rd_data, rd_keep, m_data); end
  endtask

  task automatic test_full();
    for (int i = 0; i < RATIO * DEPTH; i++) begin
      drive(1, 16'($urandom), 0, 0, 0);
      n_checks++;
      if (rd_level !== 5'(mq.size()) || almost_full !== (mq.size() >= AF_NUM) ||
          wr_full !== (mq.size() == DEPTH) || almost_empty !== (mq.size() <= AE_NUM)) begin
        n_fail++;
        $display("[TB] FAIL fill_flags: got lvl=%0d af=%b full=%b ae=%b want lvl=%0d", rd_level, almost_full, wr_full, almost_empty, mq.size());
      end
    end
    drive(1, 16'hDEAD, 0, 0, 0);
    n_checks++; if (rd_level !== 5'd16 || ovf_err !== 1'b1 || wr_full !== 1'b1) begin n_fail++; $display("[TB] FAIL overflow: got lvl=%0d ovf=%b full=%b want 16/1/1", rd_level, ovf_err, wr_full); end
    drive(1, 16'hBEEF, 1, 0, 1);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set_wins: got %b want 1", ovf_err); end
    drive(0, 0, 0, 0, 1);
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b want 0", ovf_err); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_data || rd_keep !== 8'hFF) begin n_fail++; $display("[TB] FAIL drain_word: got v=%b %h/%h want %h/ff", rd_valid, rd_data, rd_keep, m_data); end
    end
    drive(0, 0, 1, 0, 0);
    n_checks++; if (rd_level !== 5'd0) begin n_fail++; $display("[TB] FAIL dropped_lanes: got level %0d want 0", rd_level); end
  endtask

  task automatic test_underflow();
    drive(0, 0, 0, 1, 0);
    n_checks++; if (unf_err !== 1'b1 || rd_valid !== 1'b0 || rd_level !== '0) begin n_fail++; $display("[TB] FAIL underflow: got unf=%b v=%b lvl=%0d want 1/0/0", unf_err, rd_valid, rd_level); end
    drive(0, 0, 0, 0, 1);
    n_checks++; if (unf_err !== 1'b0) begin n_fail++; $display("[TB] FAIL unf_clear: got %b want 0", unf_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5 * RATIO + RATIO - 1; i++) drive(1, 16'($urandom), 0, 0, 0);
    n_checks++; if (rd_level !== 5'd5) begin n_fail++; $display("[TB] FAIL level_five: got %0d want 5", rd_level); end
    drive(1, 16'($urandom), 0, 1, 0);
    n_checks++; if (rd_level !== 5'd5 || rd_valid !== 1'b1 || rd_data !== m_data) begin n_fail++; $display("[TB] FAIL commit_and_read: got lvl=%0d v=%b %h want 5/1/%h", rd_level, rd_valid, rd_data, m_data); end
  endtask

  // Random traffic carries well over 40 words through and wraps both pointers several times.
  task automatic test_random_stream();
    logic we, fl, re, ec;
    for (int c = 0; c < 700; c++) begin
      if (c < 640) begin
        we = ($urandom % 4) != 0; fl = ($urandom % 16) == 0;
        re = ($urandom % 5) == 0; ec = ($urandom % 20) == 0;
      end else begin
        we = 0; fl = (c == 640); re = 1; ec = 0;
      end
      drive(we, 16'($urandom), fl, re, ec);
      n_checks++;
      if (rd_level !== 5'(mq.size()) || rd_empty !== (mq.size() == 0) || wr_full !== (mq.size() == DEPTH) ||
          almost_full !== (mq.size() >= AF_NUM) || almost_empty !== (mq.size() <= AE_NUM)) begin
        n_fail++;
        $display("[TB] FAIL stream_level c=%0d: got lvl=%0d e=%b f=%b af=%b ae=%b want lvl=%0d", c, rd_level, rd_empty, wr_full, almost_full, almost_empty, mq.size());
      end
      n_checks++;
      if (rd_valid !== m_valid || rd_data !== m_data || rd_keep !== m_keep) begin
        n_fail++;
        $display("[TB] FAIL stream_data c=%0d: got v=%b %h/%h want v=%b %h/%h", c, rd_valid, rd_data, rd_keep, m_valid, m_data, m_keep);
      end
      n_checks++;
      if (ovf_err !== m_ovf || unf_err !== m_unf) begin
        n_fail++;
        $display("[TB] FAIL stream_err c=%0d: got ovf=%b unf=%b want %b/%b", c, ovf_err, unf_err, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * RATIO; i++) drive(1, 16'($urandom), 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 16'hCC00 + 16'(i), 0, 0, 0);
    drive(1, 0, 0, 1, 1);
    #1 tb_rst = 1;
    model_reset();
    #2;
    n_checks++; if (rd_level !== '0 || rd_empty !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_level: got lvl=%0d e=%b ae=%b want 0/1/1", rd_level, rd_empty, almost_empty); end
    n_checks++; if ({wr_full, almost_full, rd_valid, ovf_err, unf_err} !== 5'b0 || {rd_data, rd_keep} !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_outputs: got %b %h/%h want 00000 0/0", {wr_full, almost_full, rd_valid, ovf_err, unf_err}, rd_data, rd_keep); end
    #1 tb_rst = 0;
    @(negedge clk);
    for (int i = 0; i < RATIO; i++) drive(1, 16'h7700 + 16'(i), 0, 0, 0);
    n_checks++; if (rd_level !== 5'd1) begin n_fail++; $display("[TB] FAIL clean_word_level: got %0d want 1", rd_level); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if (rd_keep !== 8'hFF || rd_data !== 128'h7707_7706_7705_7704_7703_7702_7701_7700) begin n_fail++; $display("[TB] FAIL clean_word: got %h/%h want 7707..7700/ff", rd_data, rd_keep); end
  endtask

  initial begin
    tb_rst = 0; wr_en = 0; wr_data = '0; flush = 0; rd_en = 0; err_clr = 0;
    model_reset();
    #1 tb_rst = 1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_full_word();
    test_flush();
    test_full();
    test_underflow();
    test_back_to_back();
    test_random_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
